// File: rtl/hdr_tonemap.sv
// hdr_tonemap: maps Q4.4 log-radiance pixels through per-channel (min, gain)
// registers into RGB565. Frame statistics gathered on the fly drive a
// 12-cycle restoring division that refreshes min/gain between frames.
module hdr_tonemap (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lE_red,
  input  logic [7:0] lE_green,
  input  logic [7:0] lE_blue,
  input  logic       lE_valid,
  input  logic       frame_end,
  input  logic       clr_flags,
  input  logic       pix_ready,
  output logic [4:0] pix_red,
  output logic [5:0] pix_green,
  output logic [4:0] pix_blue,
  output logic       pix_valid,
  output logic       busy,
  output logic       overflow,
  output logic       frame_overrun
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, LOAD = 2'd2} state_t;

  // 255 in Q8.4 terms: full-scale output range that gain stretches range_c onto
  localparam logic [11:0] DIVIDEND = 12'd4080;
  localparam logic [11:0] UNITY    = 12'd16;

  logic [7:0]  le_s [3];
  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  min_q [3], min_d [3], nmin_q [3], nmin_d [3];
  logic [7:0]  range_q [3], range_d [3], rem_q [3], rem_d [3];
  logic [7:0]  fmin_q [3], fmin_d [3], fmax_q [3], fmax_d [3];
  logic [11:0] gain_q [3], gain_d [3], quo_q [3], quo_d [3];
  logic [7:0]  d1_q [3], d1_d [3], m2_q [3], m2_d [3];
  logic [11:0] g1_q [3], g1_d [3];
  logic        v1_q, v1_d, v2_q, v2_d;
  logic [15:0] fifo_q [4], fifo_d [4];
  logic [1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        overflow_q, overflow_d, overrun_q, overrun_d;
  logic [7:0]  cmin_s [3], cmax_s [3];
  logic [19:0] prod_s [3];
  logic [8:0]  trial_s [3], diff_s [3];
  logic [11:0] div_sh_s;
  logic        start_s, latch_s, rd_s, wr_s, drop_s;

  assign le_s[0] = lE_red;
  assign le_s[1] = lE_green;
  assign le_s[2] = lE_blue;
  assign start_s = lE_valid & frame_end;

  assign pix_red       = fifo_q[rp_q][15:11];
  assign pix_green     = fifo_q[rp_q][10:5];
  assign pix_blue      = fifo_q[rp_q][4:0];
  assign pix_valid     = (fcnt_q != 3'd0);
  assign busy          = (state_q == CALC);
  assign overflow      = overflow_q;
  assign frame_overrun = overrun_q;

  // Pixel path: subtract/clamp with a gain snapshot, then multiply/saturate
  always_comb begin
    v1_d = lE_valid;
    v2_d = v1_q;
    for (int c = 0; c < 3; c++) begin
      d1_d[c]   = (le_s[c] > min_q[c]) ? (le_s[c] - min_q[c]) : 8'd0;
      g1_d[c]   = gain_q[c];
      prod_s[c] = {12'd0, d1_q[c]} * {8'd0, g1_q[c]};
      m2_d[c]   = (prod_s[c][19:12] != 8'd0) ? 8'hFF : prod_s[c][11:4];
    end
  end

  // Output FIFO: a write at full only lands when a read frees the slot that edge
  always_comb begin
    fifo_d = fifo_q;
    rd_s   = (fcnt_q != 3'd0) && pix_ready;
    wr_s   = v2_q && ((fcnt_q != 3'd4) || rd_s);
    drop_s = v2_q && !wr_s;
    if (wr_s) begin
      fifo_d[wp_q] = {m2_q[0][7:3], m2_q[1][7:2], m2_q[2][7:3]};
    end else begin
      fifo_d[wp_q] = fifo_q[wp_q];
    end
    wp_d   = wp_q + {1'b0, wr_s};
    rp_d   = rp_q + {1'b0, rd_s};
    fcnt_d = fcnt_q + {2'b00, wr_s} - {2'b00, rd_s};
  end

  // Frame min/max trackers, including the frame_end pixel in the latched stats
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      cmin_s[c] = (le_s[c] < fmin_q[c]) ? le_s[c] : fmin_q[c];
      cmax_s[c] = (le_s[c] > fmax_q[c]) ? le_s[c] : fmax_q[c];
      if (start_s) begin
        fmin_d[c] = 8'hFF;
        fmax_d[c] = 8'h00;
      end else if (lE_valid) begin
        fmin_d[c] = cmin_s[c];
        fmax_d[c] = cmax_s[c];
      end else begin
        fmin_d[c] = fmin_q[c];
        fmax_d[c] = fmax_q[c];
      end
    end
  end

  // Restoring divider step: next dividend bit shifted into the partial remainder
  always_comb begin
    div_sh_s = DIVIDEND << step_q;
    for (int c = 0; c < 3; c++) begin
      trial_s[c] = {rem_q[c], div_sh_s[11]};
      diff_s[c]  = trial_s[c] - {1'b0, range_q[c]};
    end
  end

  // Gain FSM; a frame_end on the LOAD edge starts the next calculation directly
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    latch_s = 1'b0;
    min_d   = min_q;
    gain_d  = gain_q;
    nmin_d  = nmin_q;
    range_d = range_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    case (state_q)
      IDLE: latch_s = start_s;
      CALC: begin
        for (int c = 0; c < 3; c++) begin
          if (trial_s[c] >= {1'b0, range_q[c]}) begin
            rem_d[c] = diff_s[c][7:0];
            quo_d[c] = {quo_q[c][10:0], 1'b1};
          end else begin
            rem_d[c] = trial_s[c][7:0];
            quo_d[c] = {quo_q[c][10:0], 1'b0};
          end
        end
        step_d  = step_q + 4'd1;
        state_d = (step_q == 4'd11) ? LOAD : CALC;
      end
      LOAD: begin
        for (int c = 0; c < 3; c++) begin
          min_d[c]  = nmin_q[c];
          gain_d[c] = (range_q[c] == 8'd0) ? UNITY : quo_q[c];
        end
        state_d = IDLE;
        latch_s = start_s;
      end
      default: state_d = IDLE;
    endcase
    state_d = latch_s ? CALC : state_d;
    step_d  = latch_s ? 4'd0 : step_d;
    for (int c = 0; c < 3; c++) begin
      range_d[c] = latch_s ? (cmax_s[c] - cmin_s[c]) : range_d[c];
      nmin_d[c]  = latch_s ? cmin_s[c] : nmin_d[c];
      rem_d[c]   = latch_s ? 8'd0 : rem_d[c];
      quo_d[c]   = latch_s ? 12'd0 : quo_d[c];
    end
  end

  // Sticky flags; a set event on the same edge as clr_flags wins
  always_comb begin
    overflow_d = drop_s ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
    overrun_d  = (start_s && (state_q == CALC)) ? 1'b1 : (clr_flags ? 1'b0 : overrun_q);
  end

  // State registers; reset restores identity mapping and empties the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= 4'd0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      wp_q       <= 2'd0;
      rp_q       <= 2'd0;
      fcnt_q     <= 3'd0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        min_q[c]   <= 8'd0;
        gain_q[c]  <= UNITY;
        nmin_q[c]  <= 8'd0;
        range_q[c] <= 8'd0;
        rem_q[c]   <= 8'd0;
        quo_q[c]   <= 12'd0;
        fmin_q[c]  <= 8'hFF;
        fmax_q[c]  <= 8'h00;
        d1_q[c]    <= 8'd0;
        g1_q[c]    <= UNITY;
        m2_q[c]    <= 8'd0;
      end
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 16'd0;
      end
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      fcnt_q     <= fcnt_d;
      overflow_q <= overflow_d;
      overrun_q  <= overrun_d;
      min_q      <= min_d;
      gain_q     <= gain_d;
      nmin_q     <= nmin_d;
      range_q    <= range_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      fmin_q     <= fmin_d;
      fmax_q     <= fmax_d;
      d1_q       <= d1_d;
      g1_q       <= g1_d;
      m2_q       <= m2_d;
      fifo_q     <= fifo_d;
    end
  end
endmodule

// File: tb/tb_hdr_tonemap.sv
// Bench for hdr_tonemap: frame-level reference model plus directed literal checks.
module tb_hdr_tonemap;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lr, lg, lb;
  logic       lv, fe, clr, rdy;
  logic [4:0] pr, pb;
  logic [5:0] pg;
  logic       pv, bsy, ovf, ovr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hdr_tonemap dut (
    .clk(clk), .rst(rst), .lE_red(lr), .lE_green(lg), .lE_blue(lb),
    .lE_valid(lv), .frame_end(fe), .clr_flags(clr), .pix_ready(rdy),
    .pix_red(pr), .pix_green(pg), .pix_blue(pb), .pix_valid(pv),
    .busy(bsy), .overflow(ovf), .frame_overrun(ovr)
  );

  // ---------------- reference model ----------------
  typedef struct { int due; logic [15:0] pix; } pend_t;
  int    mmin [3], mgain [3], fmn [3], fmx [3], nmin [3], pgain [3];
  bit    act;
  int    t0, n;
  bit    m_ovf, m_ovr, m_busy;
  logic [15:0] fq [$];
  pend_t pipe [$];

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] map_px(input int r, input int g, input int b);
    int v [3];
    int m [3];
    int d;
    v[0] = r; v[1] = g; v[2] = b;
    for (int c = 0; c < 3; c++) begin
      d = (v[c] > mmin[c]) ? v[c] - mmin[c] : 0;
      m[c] = (d * mgain[c]) / 16;
      if (m[c] > 255) m[c] = 255;
    end
    return {5'(m[0] / 8), 6'(m[1] / 4), 5'(m[2] / 8)};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      mmin[c] = 0; mgain[c] = 16; fmn[c] = 255; fmx[c] = 0;
    end
    act = 1'b0; m_ovf = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    fq.delete(); pipe.delete();
  endtask

  task automatic model_step();
    int  v [3];
    int  lo, hi, rng;
    bit  rd, drop, busy_pre, load, ovr_set;
    v[0] = lr; v[1] = lg; v[2] = lb;
    drop = 1'b0; ovr_set = 1'b0;
    rd = (fq.size() > 0) && rdy;
    if (rd) void'(fq.pop_front());
    if (pipe.size() > 0 && pipe[0].due == n) begin
      if (fq.size() < 4) fq.push_back(pipe[0].pix);
      else drop = 1'b1;
      void'(pipe.pop_front());
    end
    if (lv) pipe.push_back('{due: n + 2, pix: map_px(v[0], v[1], v[2])});
    busy_pre = act && (n >= t0 + 1) && (n <= t0 + 12);
    load     = act && (n == t0 + 13);
    if (load) begin
      for (int c = 0; c < 3; c++) begin mmin[c] = nmin[c]; mgain[c] = pgain[c]; end
      act = 1'b0;
    end
    if (lv && fe) begin
      if (busy_pre) ovr_set = 1'b1;
      else begin
        for (int c = 0; c < 3; c++) begin
          lo = (v[c] < fmn[c]) ? v[c] : fmn[c];
          hi = (v[c] > fmx[c]) ? v[c] : fmx[c];
          rng = hi - lo;
          nmin[c] = lo;
          pgain[c] = (rng == 0) ? 16 : 4080 / rng;
        end
        act = 1'b1; t0 = n;
      end
    end
    for (int c = 0; c < 3; c++) begin
      if (lv && fe) begin fmn[c] = 255; fmx[c] = 0; end
      else if (lv) begin
        if (v[c] < fmn[c]) fmn[c] = v[c];
        if (v[c] > fmx[c]) fmx[c] = v[c];
      end
    end
    m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_ovr = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_busy = act && (n >= t0) && (n <= t0 + 11);
    n++;
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pix_valid", pv, fq.size() > 0);
      chk("busy", bsy, m_busy);
      chk("overflow", ovf, m_ovf);
      chk("frame_overrun", ovr, m_ovr);
      if (fq.size() > 0) chk("pix_word", {pr, pg, pb}, fq[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic drive(input int r, input int g, input int b, input bit f);
    lr = 8'(r); lg = 8'(g); lb = 8'(b); lv = 1'b1; fe = f;
    tick();
    lv = 1'b0; fe = 1'b0;
  endtask

  task automatic get_pix(input string nm, output logic [15:0] w);
    int k = 0;
    while (!pv && k < 10) begin tick(); k++; end
    chk({nm, "_arrives"}, pv, 1'b1);
    w = {pr, pg, pb};
    tick();
  endtask

  logic [15:0] w;
  int bc;

  initial begin
    rst = 1'b1; lr = 8'd0; lg = 8'd0; lb = 8'd0;
    lv = 1'b0; fe = 1'b0; clr = 1'b0; rdy = 1'b1; n = 0;
    model_reset();
    #12;
    chk("rst_pix_valid", pv, 1'b0);
    chk("rst_busy", bsy, 1'b0);
    chk("rst_flags", {ovf, ovr}, 2'b00);
    chk("rst_pix", {pr, pg, pb}, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Identity mapping and latency
    drive(8'h40, 8'h80, 8'hFF, 1'b0);
    tick(); chk("id_not_yet", pv, 1'b0);
    tick(); chk("id_valid_after_E2", pv, 1'b1);
    chk("id_pix", {pr, pg, pb}, {5'h08, 6'h20, 5'h1F});
    tick();

    // Gain calculation from a two-pixel frame
    drive(8'h20, 8'h00, 8'h00, 1'b0);
    drive(8'h60, 8'h00, 8'h00, 1'b1);
    bc = bsy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin tick(); if (bsy) bc++; end
    chk("busy_cycles", bc, 12);
    drive(8'h60, 8'h00, 8'h00, 1'b0); get_pix("gain_60", w); chk("gain_red_60", w[15:11], 5'd31);
    drive(8'h20, 8'h00, 8'h00, 1'b0); get_pix("gain_20", w); chk("gain_red_20", w[15:11], 5'd0);
    drive(8'h10, 8'h00, 8'h00, 1'b0); get_pix("gain_10", w); chk("gain_red_10", w[15:11], 5'd0);

    // Flat frame: unity gain with min equal to the flat level
    drive(8'h00, 8'h00, 8'h00, 1'b1); idle(20);
    drive(8'h50, 8'h50, 8'h50, 1'b1); idle(20);
    drive(8'h60, 8'h50, 8'h50, 1'b0); get_pix("flat", w); chk("flat_red", w[15:11], 5'd2);

    // Backpressure: four stored, fifth dropped, drained in order
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) drive(8'h58 + 8 * i, 8'h50, 8'h50, 1'b0);
    idle(4);
    chk("bp_overflow", ovf, 1'b1);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_pix("bp_drain", w); chk("bp_order", w[15:11], 5'(i + 1));
    end
    idle(2); chk("bp_empty", pv, 1'b0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("bp_clear", ovf, 1'b0);

    // Overrun: second frame_end five cycles into CALC
    drive(8'h00, 8'h00, 8'h00, 1'b1); idle(20);
    drive(8'h10, 8'h10, 8'h10, 1'b0);
    drive(8'h50, 8'h50, 8'h50, 1'b1);
    idle(3);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    drive(8'hFF, 8'hFF, 8'hFF, 1'b1);
    chk("overrun_set", ovr, 1'b1);
    idle(20);
    drive(8'h50, 8'h10, 8'h10, 1'b0); get_pix("ovr_50", w); chk("ovr_red_50", w[15:11], 5'd31);
    drive(8'h30, 8'h10, 8'h10, 1'b0); get_pix("ovr_30", w); chk("ovr_red_30", w[15:11], 5'd15);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("overrun_clear", ovr, 1'b0);

    // Reset in the middle of CALC with pixels waiting in the FIFO
    drive(8'h00, 8'h00, 8'h00, 1'b1); idle(20);
    rdy = 1'b0;
    drive(8'h10, 8'h10, 8'h10, 1'b0);
    drive(8'h50, 8'h50, 8'h50, 1'b1);
    idle(5);
    chk("pre_rst_busy", bsy, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_busy", bsy, 1'b0);
    chk("midrst_pix_valid", pv, 1'b0);
    chk("midrst_pix", {pr, pg, pb}, 16'h0000);
    tick();
    rst = 1'b0; rdy = 1'b1;
    idle(20);
    drive(8'h40, 8'h80, 8'hFF, 1'b0); get_pix("post_rst", w);
    chk("post_rst_identity", w, {5'h08, 6'h20, 5'h1F});

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      lv  = ($urandom_range(0, 9) < 6);
      fe  = lv && ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 49) == 0);
      lr  = 8'($urandom_range(0, 255));
      lg  = 8'($urandom_range(0, 255));
      lb  = 8'($urandom_range(0, 255));
      tick();
    end
    lv = 1'b0; fe = 1'b0; clr = 1'b0; rdy = 1'b1;
    idle(30);
    chk("final_drained", pv, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
